acq_sweep_scheduler: RTL and testbench

Sequencer for the GPS acquisition engine. Steps the engine through a configured PRN range and, for each PRN, a set of Doppler bins: launches one acquisition per bin and watches the per-code-phase correlation results for the peak. After the last bin of each PRN it reports the best (peak, code phase, Doppler bin) and a detect flag over a valid/ready handshake. Sits between the host or control register block and the acquisition engine.

---
 rtl/acq_sweep_scheduler.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_acq_sweep_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sweep_scheduler.sv
// Acquisition sweep scheduler: walks the engine through a PRN range and a
// set of Doppler bins per PRN. It launches one acquisition per bin and tracks
// the strongest correlation seen across all bins of the current PRN. At the
// end of each PRN it reports that peak over a valid/ready handshake.
module acq_sweep_scheduler #(
    parameter int NUM_BINS       = 21,
    parameter int INT_W          = 12,
    parameter int CP_W           = 10,
    parameter int DOP_W          = 16,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sweep_start,
    input  logic             abort,
    input  logic [5:0]       prn_first,
    input  logic [5:0]       prn_last,
    input  logic [DOP_W-1:0] dop_min,
    input  logic [DOP_W-1:0] dop_step,
    input  logic [INT_W-1:0] threshold,
    output logic             eng_start,
    output logic [5:0]       eng_sat,
    output logic [DOP_W-1:0] eng_dop_omega,
    input  logic             eng_corr_complete,
    input  logic [CP_W-1:0]  eng_code_phase,
    input  logic [INT_W-1:0] eng_integrator,
    input  logic             eng_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       res_prn,
    output logic [5:0]       res_bin,
    output logic [CP_W-1:0]  res_code_phase,
    output logic [INT_W-1:0] res_peak,
    output logic             res_detected,
    output logic             busy,
    output logic             sweep_done,
    output logic             cfg_err,
    output logic             timeout_err
);

    localparam int PRN_W = 6;
    localparam int BIN_W = 6;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRN_W-1:0] PRN_MAX  = PRN_W'(32);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BIN,
        S_NEXT_BIN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PRN_W-1:0]   prn_q, prn_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [PRN_W-1:0]   prn_last_cfg_q, prn_last_cfg_d;
    logic [DOP_W-1:0]   dop_min_cfg_q, dop_min_cfg_d;
    logic [DOP_W-1:0]   dop_step_cfg_q, dop_step_cfg_d;
    logic [INT_W-1:0]   thr_cfg_q, thr_cfg_d;
    logic [DOP_W-1:0]   omega_q, omega_d;
    logic [INT_W-1:0]   peak_q, peak_d;
    logic [CP_W-1:0]    peak_cp_q, peak_cp_d;
    logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
    logic               corr_prev_q, corr_prev_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               eng_start_q, eng_start_d;
    logic               res_valid_q, res_valid_d;
    logic [PRN_W-1:0]   res_prn_q, res_prn_d;
    logic [BIN_W-1:0]   res_bin_q, res_bin_d;
    logic [CP_W-1:0]    res_cp_q, res_cp_d;
    logic [INT_W-1:0]   res_peak_q, res_peak_d;
    logic               res_det_q, res_det_d;
    logic               busy_q, busy_d;
    logic               sweep_done_q, sweep_done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               timeout_err_q, timeout_err_d;

    // Next-state and registered-output computation for the whole sequencer.
    // Outputs are derived from the next state so they appear in the cycle the
    // state is entered (eng_start during LAUNCH, res_valid during REPORT).
    always_comb begin
        state_d        = state_q;
        prn_d          = prn_q;
        bin_d          = bin_q;
        prn_last_cfg_d = prn_last_cfg_q;
        dop_min_cfg_d  = dop_min_cfg_q;
        dop_step_cfg_d = dop_step_cfg_q;
        thr_cfg_d      = thr_cfg_q;
        omega_d        = omega_q;
        peak_d         = peak_q;
        peak_cp_d      = peak_cp_q;
        peak_bin_d     = peak_bin_q;
        corr_prev_d    = 1'b0;
        tmo_cnt_d      = tmo_cnt_q;
        eng_start_d    = 1'b0;
        res_valid_d    = res_valid_q;
        res_prn_d      = res_prn_q;
        res_bin_d      = res_bin_q;
        res_cp_d       = res_cp_q;
        res_peak_d     = res_peak_q;
        res_det_d      = res_det_q;
        sweep_done_d   = 1'b0;
        cfg_err_d      = cfg_err_q;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    prn_last_cfg_d = prn_last;
                    dop_min_cfg_d  = dop_min;
                    dop_step_cfg_d = dop_step;
                    thr_cfg_d      = threshold;
                    cfg_err_d      = 1'b0;
                    timeout_err_d  = 1'b0;
                    if ((prn_first > prn_last) || (prn_first == '0) || (prn_last > PRN_MAX)) begin
                        cfg_err_d    = 1'b1;
                        sweep_done_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        prn_d       = prn_first;
                        bin_d       = '0;
                        omega_d     = dop_min;
                        peak_d      = '0;
                        peak_cp_d   = '0;
                        peak_bin_d  = '0;
                        tmo_cnt_d   = '0;
                        eng_start_d = 1'b1;
                        state_d     = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_BIN;
            end

            S_WAIT_BIN: begin
                corr_prev_d = eng_corr_complete;
                tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
                // Strict compare keeps the earliest sample on ties.
                if (eng_corr_complete && !corr_prev_q && (eng_integrator > peak_q)) begin
                    peak_d     = eng_integrator;
                    peak_cp_d  = eng_code_phase;
                    peak_bin_d = bin_q;
                end
                if (eng_done) begin
                    state_d = S_NEXT_BIN;
                end else if (tmo_cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_NEXT_BIN;
                end
            end

            S_NEXT_BIN: begin
                if (bin_q < LAST_BIN) begin
                    bin_d       = bin_q + BIN_W'(1);
                    omega_d     = omega_q + dop_step_cfg_q;
                    eng_start_d = 1'b1;
                    state_d     = S_LAUNCH;
                end else begin
                    res_prn_d   = prn_q;
                    res_bin_d   = peak_bin_q;
                    res_cp_d    = peak_cp_q;
                    res_peak_d  = peak_q;
                    res_det_d   = (peak_q > thr_cfg_q);
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end
            end

            S_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (prn_q < prn_last_cfg_q) begin
                        prn_d       = prn_q + PRN_W'(1);
                        bin_d       = '0;
                        omega_d     = dop_min_cfg_q;
                        peak_d      = '0;
                        peak_cp_d   = '0;
                        peak_bin_d  = '0;
                        eng_start_d = 1'b1;
                        state_d     = S_LAUNCH;
                    end else begin
                        sweep_done_d = 1'b1;
                        state_d      = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything: drop any pending pulse or result.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            eng_start_d  = 1'b0;
            res_valid_d  = 1'b0;
            sweep_done_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            prn_q          <= '0;
            bin_q          <= '0;
            prn_last_cfg_q <= '0;
            dop_min_cfg_q  <= '0;
            dop_step_cfg_q <= '0;
            thr_cfg_q      <= '0;
            omega_q        <= '0;
            peak_q         <= '0;
            peak_cp_q      <= '0;
            peak_bin_q     <= '0;
            corr_prev_q    <= 1'b0;
            tmo_cnt_q      <= '0;
            eng_start_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            res_prn_q      <= '0;
            res_bin_q      <= '0;
            res_cp_q       <= '0;
            res_peak_q     <= '0;
            res_det_q      <= 1'b0;
            busy_q         <= 1'b0;
            sweep_done_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            prn_q          <= prn_d;
            bin_q          <= bin_d;
            prn_last_cfg_q <= prn_last_cfg_d;
            dop_min_cfg_q  <= dop_min_cfg_d;
            dop_step_cfg_q <= dop_step_cfg_d;
            thr_cfg_q      <= thr_cfg_d;
            omega_q        <= omega_d;
            peak_q         <= peak_d;
            peak_cp_q      <= peak_cp_d;
            peak_bin_q     <= peak_bin_d;
            corr_prev_q    <= corr_prev_d;
            tmo_cnt_q      <= tmo_cnt_d;
            eng_start_q    <= eng_start_d;
            res_valid_q    <= res_valid_d;
            res_prn_q      <= res_prn_d;
            res_bin_q      <= res_bin_d;
            res_cp_q       <= res_cp_d;
            res_peak_q     <= res_peak_d;
            res_det_q      <= res_det_d;
            busy_q         <= busy_d;
            sweep_done_q   <= sweep_done_d;
            cfg_err_q      <= cfg_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign eng_start      = eng_start_q;
    assign eng_sat        = prn_q;
    assign eng_dop_omega  = omega_q;
    assign res_valid      = res_valid_q;
    assign res_prn        = res_prn_q;
    assign res_bin        = res_bin_q;
    assign res_code_phase = res_cp_q;
    assign res_peak       = res_peak_q;
    assign res_detected   = res_det_q;
    assign busy           = busy_q;
    assign sweep_done     = sweep_done_q;
    assign cfg_err        = cfg_err_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_acq_sweep_scheduler.sv
// Directed bench for acq_sweep_scheduler: normal two-PRN sweep with Doppler
// wrap, tie handling, result backpressure, config error, bin timeout, abort
// and asynchronous reset during REPORT. Inputs change and outputs are checked
// on the falling clock edge.
module tb_acq_sweep_scheduler;

    localparam int NUM_BINS = 3;
    localparam int INT_W    = 12;
    localparam int CP_W     = 10;
    localparam int DOP_W    = 16;
    localparam int TMO      = 100;
    localparam int WAIT_MAX = 300;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sweep_start = 1'b0;
    logic             abort = 1'b0;
    logic [5:0]       prn_first = '0;
    logic [5:0]       prn_last = '0;
    logic [DOP_W-1:0] dop_min = '0;
    logic [DOP_W-1:0] dop_step = '0;
    logic [INT_W-1:0] threshold = '0;
    logic             eng_start;
    logic [5:0]       eng_sat;
    logic [DOP_W-1:0] eng_dop_omega;
    logic             eng_corr_complete = 1'b0;
    logic [CP_W-1:0]  eng_code_phase = '0;
    logic [INT_W-1:0] eng_integrator = '0;
    logic             eng_done = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [5:0]       res_prn;
    logic [5:0]       res_bin;
    logic [CP_W-1:0]  res_code_phase;
    logic [INT_W-1:0] res_peak;
    logic             res_detected;
    logic             busy;
    logic             sweep_done;
    logic             cfg_err;
    logic             timeout_err;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_done = 0;
    int n_valid = 0;

    acq_sweep_scheduler #(
        .NUM_BINS(NUM_BINS),
        .INT_W(INT_W),
        .CP_W(CP_W),
        .DOP_W(DOP_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sweep_start(sweep_start),
        .abort(abort),
        .prn_first(prn_first),
        .prn_last(prn_last),
        .dop_min(dop_min),
        .dop_step(dop_step),
        .threshold(threshold),
        .eng_start(eng_start),
        .eng_sat(eng_sat),
        .eng_dop_omega(eng_dop_omega),
        .eng_corr_complete(eng_corr_complete),
        .eng_code_phase(eng_code_phase),
        .eng_integrator(eng_integrator),
        .eng_done(eng_done),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_prn(res_prn),
        .res_bin(res_bin),
        .res_code_phase(res_code_phase),
        .res_peak(res_peak),
        .res_detected(res_detected),
        .busy(busy),
        .sweep_done(sweep_done),
        .cfg_err(cfg_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (eng_start === 1'b1) n_start++;
        if (sweep_done === 1'b1) n_done++;
        if (res_valid === 1'b1) n_valid++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and retire all single-cycle pulses.
    task automatic tick();
        @(negedge clk);
        sweep_start       = 1'b0;
        abort             = 1'b0;
        eng_done          = 1'b0;
        eng_corr_complete = 1'b0;
        res_ready         = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while ((eng_start !== 1'b1) && (lat < WAIT_MAX));
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while ((res_valid !== 1'b1) && (lat < WAIT_MAX));
    endtask

    // Waits for a launch, checks its latency/PRN/omega, then plays n results.
    // With dwl set, eng_done rides along with the last result.
    task automatic serve_bin(input string tag, input int exp_lat, input int exp_prn,
                             input int exp_om, input int n, input int cps[3],
                             input int vals[3], input bit dwl);
        int lat;
        wait_start(lat);
        check({tag, "_start_lat"}, lat, exp_lat);
        check({tag, "_eng_sat"}, eng_sat, exp_prn);
        check({tag, "_omega"}, eng_dop_omega, exp_om);
        $display("launch %s prn=%0d omega=%04h lat=%0d", tag, eng_sat, eng_dop_omega, lat);
        tick();
        for (int i = 0; i < n; i++) begin
            eng_corr_complete = 1'b1;
            eng_code_phase    = CP_W'(cps[i]);
            eng_integrator    = INT_W'(vals[i]);
            if (i == n - 1) begin
                if (dwl) begin
                    eng_done = 1'b1;
                end else begin
                    tick();
                    eng_done = 1'b1;
                end
            end else begin
                tick();
                tick();
            end
        end
    endtask

    task automatic check_result(input string tag, input int p, input int b, input int cp,
                                input int pk, input int det);
        $display("result %s prn=%0d bin=%0d cp=%0d peak=%0d det=%0d", tag, res_prn, res_bin,
                 res_code_phase, res_peak, res_detected);
        check({tag, "_prn"}, res_prn, p);
        check({tag, "_bin"}, res_bin, b);
        check({tag, "_cp"}, res_code_phase, cp);
        check({tag, "_peak"}, res_peak, pk);
        check({tag, "_det"}, res_detected, det);
    endtask

    initial begin
        int lat;
        int s0;
        int d0;
        int v0;
        bit stable;

        // ---------------- reset ----------------
        tick();
        tick();
        check("rst_eng_start", eng_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_errs", {cfg_err, timeout_err}, 0);
        check("rst_eng_sat", eng_sat, 0);
        check("rst_omega", eng_dop_omega, 0);
        rst = 1'b0;
        tick();

        // ---------------- sweep PRN 3..4, omega wraps through 0x8000 ----------------
        s0 = n_start;
        d0 = n_done;
        prn_first   = 6'd3;
        prn_last    = 6'd4;
        dop_min     = 16'h7F00;
        dop_step    = 16'h0100;
        threshold   = 12'd600;
        sweep_start = 1'b1;
        serve_bin("p3b0", 1, 3, 32'h7F00, 2, '{1, 2, 0}, '{100, 300, 0}, 1'b0);
        check("busy_running", busy, 1);
        serve_bin("p3b1", 2, 3, 32'h8000, 3, '{5, 600, 517}, '{500, 200, 900}, 1'b1);
        serve_bin("p3b2", 2, 3, 32'h8100, 1, '{3, 0, 0}, '{800, 0, 0}, 1'b0);
        wait_result(lat);
        check("p3_res_lat", lat, 2);
        check_result("p3", 3, 1, 517, 900, 1);

        // backpressure: hold res_ready low for 50 cycles
        s0 = n_start - 6'd0;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (res_valid !== 1'b1 || res_prn !== 6'd3 || res_bin !== 6'd1 ||
                res_code_phase !== 10'd517 || res_peak !== 12'd900 || res_detected !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_no_start", n_start - s0, 0);
        res_ready = 1'b1;
        s0 = s0 - 3;
        serve_bin("p4b0", 1, 4, 32'h7F00, 1, '{7, 0, 0}, '{50, 0, 0}, 1'b0);
        check("accept_drops_valid", res_valid, 0);
        serve_bin("p4b1", 2, 4, 32'h8000, 1, '{8, 0, 0}, '{400, 0, 0}, 1'b0);
        serve_bin("p4b2", 2, 4, 32'h8100, 2, '{9, 11, 0}, '{450, 450, 0}, 1'b0);
        wait_result(lat);
        check("p4_res_lat", lat, 2);
        check_result("p4", 4, 2, 9, 450, 0);
        res_ready = 1'b1;
        tick();
        check("sweep1_done_pulse", sweep_done, 1);
        check("sweep1_busy_in_done", busy, 1);
        check("sweep1_valid_low", res_valid, 0);
        tick();
        check("sweep1_done_once", sweep_done, 0);
        check("sweep1_idle_busy", busy, 0);
        check("sweep1_starts", n_start - s0, 6);
        check("sweep1_done_count", n_done - d0, 1);

        // ---------------- tie: equal peaks, earliest wins ----------------
        prn_first   = 6'd7;
        prn_last    = 6'd7;
        dop_min     = 16'h0000;
        dop_step    = 16'hFFFF;
        sweep_start = 1'b1;
        serve_bin("tie_b0", 1, 7, 32'h0000, 2, '{10, 20, 0}, '{700, 700, 0}, 1'b0);
        serve_bin("tie_b1", 2, 7, 32'hFFFF, 1, '{1, 0, 0}, '{300, 0, 0}, 1'b0);
        serve_bin("tie_b2", 2, 7, 32'hFFFE, 2, '{30, 40, 0}, '{700, 650, 0}, 1'b0);
        wait_result(lat);
        check("tie_res_lat", lat, 2);
        check_result("tie", 7, 0, 10, 700, 1);
        res_ready = 1'b1;
        tick();
        check("tie_done_pulse", sweep_done, 1);
        tick();

        // ---------------- configuration errors ----------------
        s0 = n_start;
        v0 = n_valid;
        d0 = n_done;
        prn_first   = 6'd5;
        prn_last    = 6'd2;
        sweep_start = 1'b1;
        tick();
        check("cfg_rev_err", cfg_err, 1);
        check("cfg_rev_done", sweep_done, 1);
        check("cfg_rev_busy", busy, 1);
        tick();
        check("cfg_rev_idle", busy, 0);
        check("cfg_rev_no_start", n_start - s0, 0);
        check("cfg_rev_no_valid", n_valid - v0, 0);
        check("cfg_rev_done_count", n_done - d0, 1);
        prn_first   = 6'd1;
        prn_last    = 6'd33;
        sweep_start = 1'b1;
        tick();
        check("cfg_hi_err", cfg_err, 1);
        check("cfg_hi_done", sweep_done, 1);
        tick();
        prn_first   = 6'd0;
        prn_last    = 6'd3;
        sweep_start = 1'b1;
        tick();
        check("cfg_zero_err", cfg_err, 1);
        tick();
        check("cfg_all_no_start", n_start - s0, 0);

        // ---------------- timeout: engine never finishes ----------------
        prn_first   = 6'd1;
        prn_last    = 6'd1;
        dop_min     = 16'h0010;
        dop_step    = 16'h0005;
        sweep_start = 1'b1;
        for (int b = 0; b < NUM_BINS; b++) begin
            wait_start(lat);
            check("tmo_start_lat", lat, (b == 0) ? 1 : (TMO + 2));
            check("tmo_omega", eng_dop_omega, 32'h10 + 32'(5 * b));
            if (b == 0) begin
                check("tmo_cfg_err_cleared", cfg_err, 0);
                check("tmo_err_initial", timeout_err, 0);
            end
        end
        wait_result(lat);
        check("tmo_res_lat", lat, TMO + 2);
        check("tmo_err_set", timeout_err, 1);
        check_result("tmo", 1, 0, 0, 0, 0);
        res_ready = 1'b1;
        tick();
        check("tmo_done_pulse", sweep_done, 1);
        tick();
        check("tmo_err_sticky", timeout_err, 1);

        // ---------------- abort in WAIT_BIN ----------------
        s0 = n_start;
        d0 = n_done;
        prn_first   = 6'd2;
        prn_last    = 6'd3;
        dop_min     = 16'h0000;
        dop_step    = 16'h0001;
        sweep_start = 1'b1;
        wait_start(lat);
        check("abort_start_lat", lat, 1);
        check("abort_tmo_cleared", timeout_err, 0);
        tick();
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_eng_start", eng_start, 0);
        repeat (5) tick();
        check("abort_no_done", n_done - d0, 0);
        check("abort_one_start", n_start - s0, 1);
        check("abort_stays_idle", busy, 0);

        // ---------------- reset asserted in REPORT ----------------
        d0 = n_done;
        prn_first   = 6'd6;
        prn_last    = 6'd6;
        sweep_start = 1'b1;
        serve_bin("r_b0", 1, 6, 32'h0000, 1, '{1, 0, 0}, '{1000, 0, 0}, 1'b0);
        serve_bin("r_b1", 2, 6, 32'h0001, 1, '{2, 0, 0}, '{10, 0, 0}, 1'b0);
        serve_bin("r_b2", 2, 6, 32'h0002, 1, '{3, 0, 0}, '{20, 0, 0}, 1'b0);
        wait_result(lat);
        check("rr_res_lat", lat, 2);
        check("rr_peak", res_peak, 1000);
        rst = 1'b1;
        #1;
        check("rr_valid", res_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_peak_cleared", res_peak, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rr_no_done", n_done - d0, 0);
        check("rr_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
